// File: rtl/im_port_arb_if.sv
// Bundle of the fetch, debug and instruction-memory signals around im_port_arb.
// Handshake: a requester holds req/addr until it sees gnt in the same cycle.
// The granted read returns one cycle later as a single-cycle rvalid with rdata/rerr.
interface im_port_arb_if #(
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_rerr;

    logic              dbg_req;
    logic [31:0]       dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rerr;

    logic [31:0]       im_addr;
    logic [DATA_W-1:0] im_data;

    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, im_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_rerr,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr, im_addr
    );

    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, im_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_rerr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr, im_addr
    );
endinterface

// File: rtl/im_port_arb.sv
// Fixed-priority fetch/debug arbiter for the instruction-memory read port,
// with starvation relief for debug and registered per-port responses.
module im_port_arb #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    im_port_arb_if.slave      bus,
    output logic [3:0]        wait_cnt_o
);
    logic              dbg_win;
    logic              fetch_win;
    logic [31:0]       win_addr;
    logic              oor;
    logic [DATA_W-1:0] rdata_d;
    logic [3:0]        wait_cnt_d;
    logic [3:0]        wait_cnt_q;

    logic              fetch_rvalid_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic              fetch_rerr_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              dbg_rerr_q;

    always_comb begin
        // Grants are forced low while reset is asserted, whatever the requests.
        dbg_win   = rst_n && bus.dbg_req &&
                    (!bus.fetch_req || (wait_cnt_q == 4'(MAX_WAIT)));
        fetch_win = rst_n && bus.fetch_req && !dbg_win;
        win_addr  = dbg_win ? bus.dbg_addr : bus.fetch_addr;
        oor       = |win_addr[31:ADDR_W];
        rdata_d   = oor ? '0 : bus.im_data;

        wait_cnt_d = 4'd0;
        if (bus.dbg_req && !dbg_win) begin
            wait_cnt_d = (wait_cnt_q == 4'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q     <= 4'd0;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            fetch_rerr_q   <= 1'b0;
            dbg_rvalid_q   <= 1'b0;
            dbg_rdata_q    <= '0;
            dbg_rerr_q     <= 1'b0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            fetch_rvalid_q <= fetch_win;
            dbg_rvalid_q   <= dbg_win;
            // Data and error flag of a port that was not granted keep their last value.
            if (fetch_win) begin
                fetch_rdata_q <= rdata_d;
                fetch_rerr_q  <= oor;
            end
            if (dbg_win) begin
                dbg_rdata_q <= rdata_d;
                dbg_rerr_q  <= oor;
            end
        end
    end

    assign bus.fetch_gnt    = fetch_win;
    assign bus.dbg_gnt      = dbg_win;
    assign bus.im_addr      = win_addr;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = fetch_rdata_q;
    assign bus.fetch_rerr   = fetch_rerr_q;
    assign bus.dbg_rvalid   = dbg_rvalid_q;
    assign bus.dbg_rdata    = dbg_rdata_q;
    assign bus.dbg_rerr     = dbg_rerr_q;
    assign wait_cnt_o       = wait_cnt_q;
endmodule

// File: tb/tb_im_port_arb.sv
// Bench for im_port_arb: directed scenarios plus random traffic, checked
// against a cycle model built from the arbitration and response rules.
module tb_im_port_arb;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                streak;
    logic              pend_f, pend_d;
    logic [DATA_W:0]   hold_f, hold_d;
    logic [DATA_W:0]   fetch_q[$];
    logic [DATA_W:0]   dbg_q[$];

    im_port_arb_if #(.DATA_W(DATA_W)) bus ();

    im_port_arb #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wait_cnt_o(wait_cnt)
    );

    assign bus.im_data = mem[bus.im_addr[ADDR_W-1:0]];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W:0] resp_of(input logic [31:0] a);
        if (a >= (32'd1 << ADDR_W)) return {1'b1, {DATA_W{1'b0}}};
        return {1'b0, mem[a[ADDR_W-1:0]]};
    endfunction

    function automatic int sat_streak();
        return (streak > MAX_WAIT) ? MAX_WAIT : streak;
    endfunction

    task automatic model_reset();
        streak = 0;
        pend_f = 1'b0;
        pend_d = 1'b0;
        hold_f = '0;
        hold_d = '0;
        fetch_q.delete();
        dbg_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive, check combinational side,
    // advance one edge, then check the registered responses.
    task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
        logic exp_f, exp_d;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.dbg_req    = dr;
        bus.dbg_addr   = da;
        #1;
        // Debug wins when alone, or when it has already been refused MAX_WAIT times in a row.
        exp_d = dr && (!fr || streak >= MAX_WAIT);
        exp_f = fr && !exp_d;
        check("fetch_gnt", 64'(bus.fetch_gnt), 64'(exp_f));
        check("dbg_gnt", 64'(bus.dbg_gnt), 64'(exp_d));
        check("im_addr", 64'(bus.im_addr), 64'(exp_d ? da : fa));
        check("wait_cnt", 64'(wait_cnt), 64'(sat_streak()));
        if (exp_f) fetch_q.push_back(resp_of(fa));
        if (exp_d) dbg_q.push_back(resp_of(da));
        pend_f = exp_f;
        pend_d = exp_d;
        streak = (dr && !exp_d) ? streak + 1 : 0;
        @(posedge clk);
        #1;
        check("fetch_rvalid", 64'(bus.fetch_rvalid), 64'(pend_f));
        check("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(pend_d));
        if (pend_f && fetch_q.size() > 0) hold_f = fetch_q.pop_front();
        if (pend_d && dbg_q.size() > 0) hold_d = dbg_q.pop_front();
        check("fetch_resp", 64'({bus.fetch_rerr, bus.fetch_rdata}), 64'(hold_f));
        check("dbg_resp", 64'({bus.dbg_rerr, bus.dbg_rdata}), 64'(hold_d));
        pend_f = 1'b0;
        pend_d = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch_gnt"}, 64'(bus.fetch_gnt), 64'd0);
        check({tag, "_dbg_gnt"}, 64'(bus.dbg_gnt), 64'd0);
        check({tag, "_im_addr"}, 64'(bus.im_addr), 64'(bus.fetch_addr));
        check({tag, "_fetch_out"}, 64'({bus.fetch_rvalid, bus.fetch_rerr, bus.fetch_rdata}), 64'd0);
        check({tag, "_dbg_out"}, 64'({bus.dbg_rvalid, bus.dbg_rerr, bus.dbg_rdata}), 64'd0);
        check({tag, "_wait_cnt"}, 64'(wait_cnt), 64'd0);
    endtask

    task automatic reset_mid_read();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd5;
        bus.dbg_req    = 1'b0;
        bus.dbg_addr   = 32'h20;
        #1;
        check("pre_rst_fetch_gnt", 64'(bus.fetch_gnt), 64'd1);
        rst_n = 1'b0;
        #1;
        bus.dbg_req = 1'b1;
        #1;
        check_reset_outputs("in_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("in_rst_edge");
        @(posedge clk);
        #1;
        bus.fetch_req = 1'b0;
        bus.dbg_req   = 1'b0;
        rst_n         = 1'b1;
        model_reset();
        #1;
        check("post_rst_fetch_rvalid", 64'(bus.fetch_rvalid), 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_edge_fetch_rvalid", 64'(bus.fetch_rvalid), 64'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 4) == 0) return $urandom() | 32'h100;
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem[1] = 32'h2008_0005;
        mem[2] = 32'h2009_0007;
        mem[3] = 32'h0109_5020;

        model_reset();
        rst_n          = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd7;
        bus.dbg_req    = 1'b1;
        bus.dbg_addr   = 32'd9;
        #2;
        check_reset_outputs("init_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch-only back-to-back reads, first one in the first cycle out of reset
        step(1'b1, 32'd1, 1'b0, 32'd0);
        check("seq_word1", 64'(bus.fetch_rdata), 64'h2008_0005);
        step(1'b1, 32'd2, 1'b0, 32'd0);
        check("seq_word2", 64'(bus.fetch_rdata), 64'h2009_0007);
        step(1'b1, 32'd3, 1'b0, 32'd0);
        check("seq_word3", 64'(bus.fetch_rdata), 64'h0109_5020);
        idle(1);

        // Debug alone, then drops req the cycle after its grant
        step(1'b0, 32'd0, 1'b1, 32'h10);
        idle(2);

        // Contention: debug must win every (MAX_WAIT+1)th cycle
        for (int i = 0; i < 3 * (MAX_WAIT + 1); i++) begin
            step(1'b1, 32'(i & 8'hff), 1'b1, 32'h40);
            check("contention_dbg_slot", 64'(bus.dbg_rvalid),
                  64'((i % (MAX_WAIT + 1)) == MAX_WAIT));
        end
        idle(1);

        // Out-of-range fetch, then a valid one
        step(1'b1, 32'h100, 1'b0, 32'd0);
        check("oor_rerr", 64'({bus.fetch_rerr, bus.fetch_rdata}), 64'h1_0000_0000);
        step(1'b1, 32'h01, 1'b0, 32'd0);
        check("after_oor", 64'({bus.fetch_rerr, bus.fetch_rdata}), 64'h0_2008_0005);

        // Debug drops after two refusals, then must wait a full MAX_WAIT again
        step(1'b1, 32'd4, 1'b1, 32'h22);
        step(1'b1, 32'd5, 1'b1, 32'h22);
        step(1'b1, 32'd6, 1'b0, 32'h22);
        for (int i = 0; i <= MAX_WAIT; i++) begin
            step(1'b1, 32'(7 + i), 1'b1, 32'h23);
            check("restart_dbg_slot", 64'(bus.dbg_rvalid), 64'(i == MAX_WAIT));
        end
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 2) == 0, rnd_addr());
        end
        idle(1);

        reset_mid_read();
        step(1'b1, 32'd2, 1'b1, 32'd3);
        idle(1);

        check("fetch_q_empty", 64'(fetch_q.size()), 64'd0);
        check("dbg_q_empty", 64'(dbg_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Time-limit guard so the run always ends on its own
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/im_port_arb.md
# im_port_arb

Two-requester arbiter for the single combinational read port of the instruction memory. It shares the port between the instruction-fetch stage and a debug/test-dump reader. Fetch has fixed priority, with a bounded-starvation guarantee for the debug port. Responses are registered, so every granted read returns exactly one cycle later on the winner's response bus.

## Interface
- ADDR_W, 8, index width of the instruction memory (256 words); addresses with any bit set at or above ADDR_W are out of range
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, consecutive denied debug cycles after which debug wins; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request; held with fetch_addr until fetch_gnt
- fetch_addr  in  32  fetch word address
- fetch_gnt  out  1  combinational grant to fetch, same cycle as request
- fetch_rvalid  out  1  registered; one-cycle pulse carrying the fetch response
- fetch_rdata  out  DATA_W  registered fetch read data
- fetch_rerr  out  1  registered; out-of-range address flag for fetch
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr  same directions, widths and meanings as the fetch set, for the debug requester
- im_addr  out  32  address to the instruction memory read port
- im_data  in  DATA_W  combinational read data from the instruction memory

## Operation
- Arbitration happens every cycle and is combinational from the req signals and the wait counter.
- Only fetch_req is high: fetch wins.
- Only dbg_req is high: debug wins.
- Both are high: fetch wins, unless wait_cnt == MAX_WAIT, in which case debug wins.
- Neither is high: no grant.
- Exactly one gnt may be high in any cycle.
- im_addr = winner's address. With no winner, im_addr = fetch_addr.
- Range check: if the winner's address has any bit set in [31:ADDR_W], the read is still granted and consumes the slot. The response carries rerr=1 and rdata=0; im_data is ignored.
- Wait counter, 4 bits:
  - dbg_req && !dbg_gnt: increment, saturating at MAX_WAIT.
  - dbg_gnt, or dbg_req low: clear to 0.
  - It therefore counts consecutive denied debug cycles only.
- Response registers are updated on each rising edge:
  - Winner's rvalid <= 1.
  - Winner's rdata <= im_data, or 0 if out of range.
  - Winner's rerr <= the range-check result.
  - Loser's, or idle port's, rvalid <= 0.
  - rdata and rerr of a port not granted hold their last value.
- Requesters may drop req before gnt without penalty; no response is generated for an ungranted request.
- A requester may re-request in the cycle after gnt (back-to-back), giving one read per cycle for that port.

## Timing
- Grant: 0-cycle latency, combinational with req.
- Read data: exactly 1 cycle after grant, rvalid high for exactly one cycle per grant.
- Maximum debug wait under continuous fetch traffic: MAX_WAIT denied cycles. Debug is granted on cycle MAX_WAIT+1 of its request.
- Fetch stall caused by starvation relief: 1 cycle per relief event. After a debug grant the counter is 0, so fetch regains priority next cycle.
- Reset (rst_n low, asynchronous):
  - fetch_gnt = dbg_gnt = 0 combinationally, regardless of req.
  - rvalid, rdata and rerr = 0 on both ports.
  - wait_cnt = 0.
  - im_addr follows fetch_addr.
- Reset mid-read: a response pending for the next edge is discarded; no rvalid appears after reset release for a grant issued before reset.
- First grant is possible in the first cycle with rst_n high; its response follows on the next edge.
- Simultaneous dbg grant and dbg_req deassertion in the following cycle: the counter stays 0 and the response is still delivered.

## Test plan
- Fetch-only reads at addr 1, 2, 3 back-to-back, with memory preloaded with 0x20080005/0x20090007/0x01095020 -> fetch_gnt high each cycle, fetch_rvalid high on cycles 2-4 with those words in order, dbg_rvalid never high.
- dbg_req held at addr 0x10 with fetch idle -> dbg_gnt same cycle, dbg_rvalid one cycle later with mem[0x10], wait_cnt stays 0.
- fetch_req and dbg_req both held continuously, MAX_WAIT=4 -> fetch granted 4 cycles, debug granted on the 5th, fetch granted again on the 6th; the pattern repeats every 5 cycles; never two grants in one cycle.
- Out-of-range: fetch_addr=0x100 -> fetch_gnt=1, next cycle fetch_rvalid=1, fetch_rerr=1, fetch_rdata=0. A following read at 0x01 -> rerr=0 with valid data.
- Debug request dropped after 2 denied cycles, then re-raised under continuous fetch -> counter restarts from 0, and debug is granted only after 4 more denied cycles.
- rst_n pulled low in the same cycle as a fetch grant -> no fetch_rvalid after release, all outputs 0 during reset, gnt low while rst_n low even with both reqs high.
